// File: rtl/output_layer_accumulator_if.sv
// Activation/weight input stream and packed-sum output stream of the output layer.
`ifndef SOFTMAX_IN_BIT_WIDTH
`define SOFTMAX_IN_BIT_WIDTH 16
`endif

interface output_layer_accumulator_if #(
  parameter int IN_WIDTH  = 8,
  parameter int W_WIDTH   = 8,
  parameter int SUM_WIDTH = `SOFTMAX_IN_BIT_WIDTH
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_WIDTH-1:0]     act_in;
  logic [10*W_WIDTH-1:0]   weight_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [10*SUM_WIDTH-1:0] sum_out;

  modport master (
    output in_valid, act_in, weight_in, out_ready,
    input  in_ready, out_valid, sum_out
  );

  modport slave (
    input  in_valid, act_in, weight_in, out_ready,
    output in_ready, out_valid, sum_out
  );
endinterface

// File: rtl/output_layer_accumulator.sv
// Final fully-connected layer: 10 parallel saturating MACs over NUM_INPUTS beats,
// result held as a packed signed vector until the softMax stage consumes it.
`ifndef SOFTMAX_IN_BIT_WIDTH
`define SOFTMAX_IN_BIT_WIDTH 16
`endif

module output_layer_accumulator #(
  parameter int IN_WIDTH   = 8,
  parameter int W_WIDTH    = 8,
  parameter int NUM_INPUTS = 16,
  parameter int SUM_WIDTH  = `SOFTMAX_IN_BIT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  output_layer_accumulator_if.slave    bus
);
  localparam int NEURONS = 10;
  localparam int PW = IN_WIDTH + 1 + W_WIDTH;
  localparam int AW = ((PW > SUM_WIDTH) ? PW : SUM_WIDTH) + 1;
  localparam int CW = $clog2(NUM_INPUTS);
  // Symmetric clamp: the most-negative code is never produced.
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-SUM_WIDTH+1){1'b0}}, {(SUM_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = -SAT_HI;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                        state;
  logic [CW-1:0]                 count;
  logic signed [SUM_WIDTH-1:0]   acc      [NEURONS];
  logic signed [SUM_WIDTH-1:0]   acc_next [NEURONS];
  logic signed [PW-1:0]          prod     [NEURONS];
  logic signed [AW-1:0]          total    [NEURONS];
  logic signed [IN_WIDTH:0]      act_s;
  logic [NEURONS*SUM_WIDTH-1:0]  sum_next;
  logic [NEURONS*SUM_WIDTH-1:0]  sum_q;
  logic                          last_beat;

  assign last_beat = (count == CW'(NUM_INPUTS - 1));

  always_comb begin
    act_s    = signed'({1'b0, bus.act_in});
    sum_next = '0;
    for (int unsigned k = 0; k < NEURONS; k++) begin
      prod[k]  = PW'(act_s) * PW'(signed'(bus.weight_in[(NEURONS-1-k)*W_WIDTH +: W_WIDTH]));
      // Beat 0 loads the product directly, discarding the previous inference.
      total[k] = ((count == '0) ? '0 : AW'(acc[k])) + AW'(prod[k]);
      if (total[k] > SAT_HI)
        acc_next[k] = SAT_HI[SUM_WIDTH-1:0];
      else if (total[k] < SAT_LO)
        acc_next[k] = SAT_LO[SUM_WIDTH-1:0];
      else
        acc_next[k] = total[k][SUM_WIDTH-1:0];
      sum_next[(NEURONS-1-k)*SUM_WIDTH +: SUM_WIDTH] = acc_next[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      count <= '0;
      sum_q <= '0;
      for (int unsigned k = 0; k < NEURONS; k++) acc[k] <= '0;
    end else if (flush) begin
      state <= ACCUM;
      count <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            for (int unsigned k = 0; k < NEURONS; k++) acc[k] <= acc_next[k];
            if (last_beat) begin
              sum_q <= sum_next;
              count <= '0;
              state <= HOLD;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == HOLD);
  assign bus.sum_out   = sum_q;
endmodule
